// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the pipelined unsigned divider and its result buffer.
//   DIV_WIDTH   : default quotient/remainder width.
//   DIV_DEPTH   : default result-buffer depth.
//   div_entry_t : result record {error, quotient, remainder} at DIV_WIDTH.
//   cnt_width() : bits needed to hold a count 0..n inclusive.
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_DEPTH = 64;

    typedef struct packed {
        logic                 error;
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
    } div_entry_t;

    // Width of a counter that must represent every value from 0 to n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DIV_CW = cnt_width(DIV_DEPTH);

endpackage

// File: rtl/div_result_fifo.sv
// ----------------------------------------------------------------------------
// div_result_fifo
// Show-ahead FIFO holding packed divider results {error, quotient, remainder}.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers only).
//   push_i       : write wr_data_i this cycle (dropped if full and no pop).
//   pop_i        : remove the head entry (ignored when empty).
//   wr_data_i    : entry to write.
//   rd_data_o    : head entry, forced to zero while empty.
//   empty_o      : no entries stored.
//   full_o       : DEPTH entries stored.
// Handshake: the caller only asserts pop_i together with !empty_o; an entry
// is consumed exactly on a cycle where pop_i && !empty_o at the rising edge.
// ----------------------------------------------------------------------------
module div_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [2*WIDTH:0] wr_data_i,
    output logic [2*WIDTH:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int EW = 2 * WIDTH + 1;
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands (it overwrites the head slot only after the head is read).
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only slots behind a valid pointer are read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/div_result_buffer.sv
// ----------------------------------------------------------------------------
// div_result_buffer
// Captures every divider result into a FIFO and presents it on a valid/ready
// stream. A credit counter gates divider launches so a result always finds a
// free slot when it leaves the non-stallable divider pipeline.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset.
//   issue_req / issue_grant    : launch request / combinational grant
//                                (grant = issue_req && credits != 0).
//   done_i, error_i            : divider completion and divide-by-zero flag.
//   quotient_i, remainder_i    : divider result.
//   out_valid / out_ready      : result stream; a transfer happens on a rising
//                                edge where both are high; out_* hold steady
//                                while out_valid && !out_ready.
//   out_quotient/remainder/error : head entry (zero while empty).
//   credits                    : free slots not promised to in-flight divides.
//   overflow                   : sticky, a result arrived with the FIFO full.
// ----------------------------------------------------------------------------
module div_result_buffer
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    parameter  int DEPTH = DIV_DEPTH,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_req,
    output logic             issue_grant,
    input  logic             done_i,
    input  logic             error_i,
    input  logic [WIDTH-1:0] quotient_i,
    input  logic [WIDTH-1:0] remainder_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_error,
    output logic [CW-1:0]    credits,
    output logic             overflow
);

    logic             push;
    logic             pop;
    logic [2*WIDTH:0] wr_entry;
    logic [2*WIDTH:0] rd_entry;
    logic             fifo_empty;
    logic             fifo_full;

    logic [CW-1:0]    credits_q, credits_d;
    logic             overflow_q, overflow_d;

    assign push = done_i | error_i;
    assign pop  = out_valid && out_ready;

    // A divide-by-zero carries no meaningful quotient/remainder.
    assign wr_entry = error_i ? {1'b1, {(2 * WIDTH){1'b0}}}
                              : {1'b0, quotient_i, remainder_i};

    div_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign out_valid     = !fifo_empty;
    assign out_error     = rd_entry[2*WIDTH];
    assign out_quotient  = rd_entry[2*WIDTH-1:WIDTH];
    assign out_remainder = rd_entry[WIDTH-1:0];

    // Depends only on issue_req and registered credits; no path from done_i
    // or out_ready.
    assign issue_grant = issue_req && (credits_q != '0);

    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        case ({issue_grant, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
        // A same-cycle pop makes room, so only an unrelieved full FIFO drops.
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q  <= CW'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    assign credits  = credits_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_div_result_buffer
// Directed bench for div_result_buffer (WIDTH 32, DEPTH 64). Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 unit after inputs
// settle, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_div_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_req;
    logic             issue_grant;
    logic             done_i;
    logic             error_i;
    logic [WIDTH-1:0] quotient_i;
    logic [WIDTH-1:0] remainder_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_error;
    logic [CW-1:0]    credits;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    div_result_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_req     (issue_req),
        .issue_grant   (issue_grant),
        .done_i        (done_i),
        .error_i       (error_i),
        .quotient_i    (quotient_i),
        .remainder_i   (remainder_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_error     (out_error),
        .credits       (credits),
        .overflow      (overflow)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        issue_req   = 1'b0;
        done_i      = 1'b0;
        error_i     = 1'b0;
        quotient_i  = '0;
        remainder_i = '0;
        out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    int grants;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        tick();
        settle();
        check("rst_credits", 64'(credits), 64'd64);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_quotient", 64'(out_quotient), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---------- single result ----------
        issue_req = 1'b1;
        settle();
        check("single_grant", 64'(issue_grant), 64'd1);
        tick();
        issue_req   = 1'b0;
        done_i      = 1'b1;
        quotient_i  = 32'd3;
        remainder_i = 32'd1;
        settle();
        check("single_credits_dec", 64'(credits), 64'd63);
        check("single_valid_before", 64'(out_valid), 64'd0);
        tick();
        idle_inputs();
        settle();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_quot", 64'(out_quotient), 64'd3);
        check("single_rem", 64'(out_remainder), 64'd1);
        check("single_err", 64'(out_error), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        check("single_credits_back", 64'(credits), 64'd64);
        check("single_empty", 64'(out_valid), 64'd0);

        // ---------- divide-by-zero entry ----------
        issue_req = 1'b1;
        tick();
        issue_req   = 1'b0;
        done_i      = 1'b1;
        error_i     = 1'b1;
        quotient_i  = 32'hDEAD;
        remainder_i = 32'h5;
        tick();
        idle_inputs();
        settle();
        check("dz_valid", 64'(out_valid), 64'd1);
        check("dz_err", 64'(out_error), 64'd1);
        check("dz_quot", 64'(out_quotient), 64'd0);
        check("dz_rem", 64'(out_remainder), 64'd0);
        tick();
        check("dz_hold_err", 64'(out_error), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        check("dz_credits_back", 64'(credits), 64'd64);

        // ---------- credit exhaustion ----------
        grants    = 0;
        issue_req = 1'b1;
        for (int i = 0; i < 70; i++) begin
            settle();
            if (issue_grant) grants++;
            tick();
        end
        settle();
        check("exh_grants", 64'(grants), 64'd64);
        check("exh_grant_low", 64'(issue_grant), 64'd0);
        check("exh_credits", 64'(credits), 64'd0);
        issue_req = 1'b0;
        for (int i = 0; i < 64; i++) begin
            done_i      = 1'b1;
            quotient_i  = 32'(i);
            remainder_i = 32'(i + 100);
            tick();
        end
        idle_inputs();
        settle();
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_head_q", 64'(out_quotient), 64'd0);
        check("full_head_r", 64'(out_remainder), 64'd100);
        check("full_overflow", 64'(overflow), 64'd0);
        // One ready pulse returns exactly one credit.
        issue_req = 1'b1;
        out_ready = 1'b1;
        settle();
        check("pulse_grant_before", 64'(issue_grant), 64'd0);
        tick();
        out_ready = 1'b0;
        settle();
        check("pulse_grant_next", 64'(issue_grant), 64'd1);
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (issue_grant) grants++;
            tick();
        end
        issue_req = 1'b0;
        settle();
        check("pulse_grants", 64'(grants), 64'd1);
        check("pulse_head", 64'(out_quotient), 64'd1);
        check("pulse_credits", 64'(credits), 64'd0);
        // Result of the extra grant fills the FIFO again (1..64).
        done_i     = 1'b1;
        quotient_i = 32'd64;
        tick();
        // Push and pop while full: accepted, no overflow.
        quotient_i = 32'd65;
        out_ready  = 1'b1;
        tick();
        idle_inputs();
        settle();
        check("pp_full_overflow", 64'(overflow), 64'd0);
        check("pp_full_head", 64'(out_quotient), 64'd2);
        // Forced overflow: push while full, no pop.
        done_i     = 1'b1;
        quotient_i = 32'hBAD;
        tick();
        idle_inputs();
        settle();
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_head", 64'(out_quotient), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            settle();
            check("drain_order", 64'(out_quotient), 64'(k + 2));
            tick();
        end
        out_ready = 1'b0;
        settle();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // ---------- steady state across pointer wrap ----------
        do_reset();
        settle();
        check("rst2_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 10; i++) begin
            issue_req  = 1'b1;
            done_i     = 1'b1;
            quotient_i = 32'(i);
            tick();
        end
        idle_inputs();
        settle();
        check("ss_credits_pre", 64'(credits), 64'd54);
        for (int k = 0; k < 100; k++) begin
            issue_req  = 1'b1;
            out_ready  = 1'b1;
            done_i     = 1'b1;
            quotient_i = 32'(k + 10);
            settle();
            check("ss_order", 64'(out_quotient), 64'(k));
            tick();
            if (k % 20 == 19) begin
                check("ss_credits", 64'(credits), 64'd54);
            end
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        settle();
        check("ss_credits_post", 64'(credits), 64'd59);
        check("ss_head", 64'(out_quotient), 64'd105);

        // ---------- reset mid-stream with 5 queued ----------
        rst_n = 1'b0;
        settle();
        check("mid_rst_credits", 64'(credits), 64'd64);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post_rst_valid", 64'(out_valid), 64'd0);
        end
        check("post_rst_credits", 64'(credits), 64'd64);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
